// File: rtl/ram_port_arbiter.sv
// +------------------------------------------------------------------------+
// | Module : ram_port_arbiter                                              |
// | Brief  : Two-port arbiter sequencing accesses to a single-port RAM.    |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module ram_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              CLK,
  input  logic              Rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack1,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_rw,
  output logic              ram_cs
);

  localparam int                c_CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CW-1:0]   c_LIMIT = c_CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_id;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_CW-1:0]     r_starve;
  logic                w_any;
  logic                w_win1;

  // Port 1 has priority unless port 0 has already lost STARVE_LIMIT times in a row
  assign w_any  = req0 | req1;
  assign w_win1 = req1 & ~(req0 & (r_starve == c_LIMIT));

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_id     <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_starve <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        if (w_win1 && req0)
          r_starve <= (r_starve == c_LIMIT) ? c_LIMIT : r_starve + c_CW'(1);
        else
          r_starve <= '0;
        if (w_any) begin
          r_id    <= w_win1;
          r_we    <= w_win1 ? we1    : we0;
          r_addr  <= w_win1 ? addr1  : addr0;
          r_wdata <= w_win1 ? wdata1 : wdata0;
        end
      end
      if (r_state == S_ACCESS && !r_we) begin
        if (r_id) rdata1 <= ram_data;
        else      rdata0 <= ram_data;
      end
    end
  end

  // Outputs decode straight from state so an async reset drops CS/RW at once
  always_comb begin
    w_next = r_state;
    ack0   = 1'b0;
    ack1   = 1'b0;
    busy   = 1'b1;
    ram_cs = 1'b0;
    ram_rw = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_any) w_next = S_GRANT;
      end
      S_GRANT: begin
        ram_rw = r_we;
        w_next = S_ACCESS;
      end
      S_ACCESS: begin
        ram_rw = r_we;
        ram_cs = 1'b1;
        w_next = S_ACK;
      end
      S_ACK: begin
        ack0   = ~r_id;
        ack1   = r_id;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign ram_addr = r_addr;
  assign ram_data = (r_state == S_ACCESS && r_we) ? r_wdata : {DATA_W{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// +------------------------------------------------------------------------+
// | Module : tb_ram_port_arbiter                                           |
// | Brief  : Scoreboard bench for ram_port_arbiter with a behavioural RAM. |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ram_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic              CLK = 1'b0;
  logic              Rst_n = 1'b1;
  logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ack0, ack1, busy, ram_rw, ram_cs;
  logic [ADDR_W-1:0] ram_addr;
  wire  [DATA_W-1:0] ram_data;

  logic [DATA_W-1:0] mem [0:4095];
  bit                written [0:4095];
  exp_t              sb [$];
  int                cyc = 0;
  int                cs_cnt = 0;
  int                checks = 0;
  int                errors = 0;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(3)) dut (
    .CLK(CLK), .Rst_n(Rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
    .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data), .ram_rw(ram_rw), .ram_cs(ram_cs)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Unwritten RAM words read back as C0DE0 followed by their address
  function automatic logic [31:0] rd_mem(input logic [11:0] a);
    return written[a] ? mem[a] : {20'hC0DE0, a};
  endfunction

  assign ram_data = (ram_cs && !ram_rw) ? rd_mem(ram_addr) : 32'hzzzzzzzz;

  always @(negedge CLK) begin
    if (ram_cs && ram_rw) begin
      mem[ram_addr]     <= ram_data;
      written[ram_addr] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (Rst_n) begin
        if (ram_cs) cs_cnt++;
        if (ack0 || ack1) begin
          chk("ack_overlap", {31'b0, ack0 & ack1}, 32'd0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack actual=ack0:%0b/ack1:%0b at cycle %0d required=no ack",
                     ack0, ack1, cyc);
          end else begin
            e = sb.pop_front();
            chk("ack_port", {31'b0, ack1}, {31'b0, e.port});
            chk("ack_cycle", cyc, e.cyc);
            chk(e.port ? "rdata1" : "rdata0", e.port ? rdata1 : rdata0, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input bit p, input logic [31:0] rd, input int c);
    exp_t e;
    e.port = p; e.rdata = rd; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check_reset();
    chk("rst_cs",    {31'b0, ram_cs}, 32'd0);
    chk("rst_rw",    {31'b0, ram_rw}, 32'd0);
    chk("rst_addr",  {20'b0, ram_addr}, 32'd0);
    chk("rst_acks",  {30'b0, ack0, ack1}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
  endtask

  // Single isolated access issued from IDLE; ack expected three cycles later
  task automatic single_access(input bit p, input bit we, input logic [11:0] a,
                               input logic [31:0] wd, input logic [31:0] exp_rd);
    int k;
    k = cyc;
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    push(p, exp_rd, k + 3);
    step(3);
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    step(2);
  endtask

  initial begin
    int k;
    fork
      monitor();
    join_none

    // Reset asserted mid-cycle
    #13 Rst_n = 1'b0;
    #1 check_reset();
    step(2);
    Rst_n = 1'b1;
    step(2);

    // Port 1 write then read back
    single_access(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0000_0000);
    chk("mem_010", rd_mem(12'h010), 32'hDEADBEEF);
    single_access(1'b1, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF);

    // Port 0 read alone
    single_access(1'b0, 1'b0, 12'h000, 32'h0, 32'hC0DE0000);

    // Both ports requesting continuously: grant order 1,1,1,0,1,1,1,0
    k = cyc;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h010;
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 3) push(1'b0, 32'hC0DE0000, k + 3 + 4 * i);
      else            push(1'b1, 32'hDEADBEEF, k + 3 + 4 * i);
    end
    step(31);
    req0 = 1'b0; req1 = 1'b0;
    step(2);

    // Reset during a write ACCESS aborts the write
    req1 = 1'b1; we1 = 1'b1; addr1 = 12'h020; wdata1 = 32'h12345678;
    step(2);
    chk("in_access_cs", {31'b0, ram_cs}, 32'd1);
    #1 Rst_n = 1'b0;
    #1 check_reset();
    req1 = 1'b0; we1 = 1'b0;
    step(1);
    Rst_n = 1'b1;
    step(2);
    chk("mem_020", rd_mem(12'h020), 32'hC0DE0020);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    // Port 1 read held high: back-to-back every 4 cycles
    k = cyc;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h010;
    for (int i = 0; i < 3; i++) push(1'b1, 32'hDEADBEEF, k + 3 + 4 * i);
    for (int c = 1; c <= 11; c++) begin
      step(1);
      chk("busy_pattern", {31'b0, busy}, {31'b0, (c % 4) != 0});
    end
    req1 = 1'b0;
    step(3);

    chk("sb_empty", sb.size(), 32'd0);
    chk("cs_count", cs_cnt, 32'd14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
